id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register that consumes the forwarding unit's outputs: `is_fwd_a/b`, `dat_fwd_a/b` and `stall`.
- Selects each source operand from forwarded data or register-file data and latches the decoded instruction into EX.
- Inserts a bubble on a hazard stall, holds on EX backpressure and kills its contents on flush.
- Drives `EX_rd` / `EX_inst` back to the forwarding unit, so an empty slot must never alias a real register.

---
 rtl/core_pkg.sv | 17 +
 rtl/operand_sel.sv | 23 ++
 rtl/id_ex_stage.sv | 106 ++++++++++
 tb/tb_id_ex_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, result-class encodings used by the
// ID/EX register and the forwarding unit, and the EX slot state type.
package core_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [1:0] INST_WB  = 2'b00;
    localparam logic [1:0] INST_EX  = 2'b01;
    localparam logic [1:0] INST_MEM = 2'b10;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

endpackage

// File: rtl/operand_sel.sv
// Per-operand source mux: x0 reads as zero, otherwise forwarded data wins over
// the register-file read port.
module operand_sel
    import core_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             is_fwd,
    input  logic [XLEN-1:0]  fwd_dat,
    input  logic [XLEN-1:0]  rf_dat,
    output logic [XLEN-1:0]  dat
);

    always_comb begin
        if (rs == '0) begin
            dat = '0;
        end else if (is_fwd) begin
            dat = fwd_dat;
        end else begin
            dat = rf_dat;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: operand selection, bubble insertion on hazard
// stall, hold on EX backpressure, flush, and a saturating stall counter.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [REG_W-1:0]  id_rs1_i,
    input  logic [REG_W-1:0]  id_rs2_i,
    input  logic [REG_W-1:0]  id_rd_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [1:0]        id_inst_i,
    input  logic [XLEN-1:0]   rf_rs1_dat_i,
    input  logic [XLEN-1:0]   rf_rs2_dat_i,
    input  logic              is_fwd_a_i,
    input  logic              is_fwd_b_i,
    input  logic [XLEN-1:0]   dat_fwd_a_i,
    input  logic [XLEN-1:0]   dat_fwd_b_i,
    input  logic              fwd_stall_i,
    input  logic              flush_i,
    input  logic              ex_ready_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_rs1_dat_o,
    output logic [XLEN-1:0]   ex_rs2_dat_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [REG_W-1:0]  ex_rd_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [1:0]        ex_inst_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    slot_t            state;
    logic             adv;
    logic             take;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;

    assign ex_valid_o = (state == SLOT_FULL);
    assign adv        = !ex_valid_o || ex_ready_i;
    assign id_ready_o = adv && !fwd_stall_i && !flush_i;
    assign take       = id_valid_i && id_ready_o;

    operand_sel u_sel_a (
        .rs      (id_rs1_i),
        .is_fwd  (is_fwd_a_i),
        .fwd_dat (dat_fwd_a_i),
        .rf_dat  (rf_rs1_dat_i),
        .dat     (op_a)
    );

    operand_sel u_sel_b (
        .rs      (id_rs2_i),
        .is_fwd  (is_fwd_b_i),
        .fwd_dat (dat_fwd_b_i),
        .rf_dat  (rf_rs2_dat_i),
        .dat     (op_b)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= SLOT_EMPTY;
            ex_pc_o      <= '0;
            ex_rs1_dat_o <= '0;
            ex_rs2_dat_o <= '0;
            ex_imm_o     <= '0;
            ex_rd_o      <= '0;
            ex_ctrl_o    <= '0;
            ex_inst_o    <= INST_WB;
            stall_cnt_o  <= '0;
        end else begin
            if (id_valid_i && fwd_stall_i && !flush_i && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end

            // An empty slot always carries rd=0 / class WB so the forwarding
            // unit never matches or stalls against a bubble.
            if (flush_i) begin
                state     <= SLOT_EMPTY;
                ex_rd_o   <= '0;
                ex_inst_o <= INST_WB;
            end else if (take) begin
                state        <= SLOT_FULL;
                ex_pc_o      <= id_pc_i;
                ex_rs1_dat_o <= op_a;
                ex_rs2_dat_o <= op_b;
                ex_imm_o     <= id_imm_i;
                ex_rd_o      <= id_rd_i;
                ex_ctrl_o    <= id_ctrl_i;
                ex_inst_o    <= id_inst_i;
            end else if (adv) begin
                state     <= SLOT_EMPTY;
                ex_rd_o   <= '0;
                ex_inst_o <= INST_WB;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded bench for id_ex_stage: directed ID instructions push expected EX
// contents; a negedge monitor compares each EX instruction as it leaves.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [15:0] ctrl;
        logic [1:0]  inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm;
    logic [15:0] id_ctrl;
    logic [1:0]  id_inst;
    logic [31:0] rf1, rf2;
    logic        is_fwd_a, is_fwd_b;
    logic [31:0] dat_fwd_a, dat_fwd_b;
    logic        fwd_stall, flush, ex_ready;

    logic        id_ready, ex_valid;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl;
    logic [1:0]  ex_inst;
    logic [15:0] cnt;

    logic        id_ready4, ex_valid4;
    logic [31:0] ex_pc4, ex_a4, ex_b4, ex_imm4;
    logic [4:0]  ex_rd4;
    logic [15:0] ex_ctrl4;
    logic [1:0]  ex_inst4;
    logic [3:0]  cnt4;

    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    id_ex_stage #(.CTRL_W(16), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(id_ready),
        .id_pc_i(id_pc), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_imm_i(id_imm), .id_ctrl_i(id_ctrl), .id_inst_i(id_inst),
        .rf_rs1_dat_i(rf1), .rf_rs2_dat_i(rf2),
        .is_fwd_a_i(is_fwd_a), .is_fwd_b_i(is_fwd_b),
        .dat_fwd_a_i(dat_fwd_a), .dat_fwd_b_i(dat_fwd_b),
        .fwd_stall_i(fwd_stall), .flush_i(flush), .ex_ready_i(ex_ready),
        .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rs1_dat_o(ex_a),
        .ex_rs2_dat_o(ex_b), .ex_imm_o(ex_imm), .ex_rd_o(ex_rd),
        .ex_ctrl_o(ex_ctrl), .ex_inst_o(ex_inst), .stall_cnt_o(cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    id_ex_stage #(.CTRL_W(16), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(id_ready4),
        .id_pc_i(id_pc), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_imm_i(id_imm), .id_ctrl_i(id_ctrl), .id_inst_i(id_inst),
        .rf_rs1_dat_i(rf1), .rf_rs2_dat_i(rf2),
        .is_fwd_a_i(is_fwd_a), .is_fwd_b_i(is_fwd_b),
        .dat_fwd_a_i(dat_fwd_a), .dat_fwd_b_i(dat_fwd_b),
        .fwd_stall_i(fwd_stall), .flush_i(flush), .ex_ready_i(ex_ready),
        .ex_valid_o(ex_valid4), .ex_pc_o(ex_pc4), .ex_rs1_dat_o(ex_a4),
        .ex_rs2_dat_o(ex_b4), .ex_imm_o(ex_imm4), .ex_rd_o(ex_rd4),
        .ex_ctrl_o(ex_ctrl4), .ex_inst_o(ex_inst4), .stall_cnt_o(cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] imm, input logic [15:0] ctrl,
                          input logic [1:0] inst);
        id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_imm = imm; id_ctrl = ctrl; id_inst = inst;
    endtask

    // Monitor: an EX instruction leaves when EX accepts it or it is flushed.
    always @(negedge clk) begin
        if (!rst) begin
            if (ex_valid) begin
                if (ex_ready || flush) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: unexpected EX pc 0x%08h", ex_pc);
                    end else begin
                        e = sb.pop_front();
                        pops++;
                        chk("sb_pc",   ex_pc,   e.pc);
                        chk("sb_a",    ex_a,    e.a);
                        chk("sb_b",    ex_b,    e.b);
                        chk("sb_imm",  ex_imm,  e.imm);
                        chk("sb_rd",   {27'd0, ex_rd},   {27'd0, e.rd});
                        chk("sb_ctrl", {16'd0, ex_ctrl}, {16'd0, e.ctrl});
                        chk("sb_inst", {30'd0, ex_inst}, {30'd0, e.inst});
                    end
                end
            end else begin
                chk("empty_rd",   {27'd0, ex_rd},   32'd0);
                chk("empty_inst", {30'd0, ex_inst}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_model;
        rst = 1'b1; id_valid = 1'b1; ex_ready = 1'b1; fwd_stall = 1'b0; flush = 1'b0;
        is_fwd_a = 1'b0; is_fwd_b = 1'b0; dat_fwd_a = '0; dat_fwd_b = '0;
        rf1 = 32'h5555_5555; rf2 = 32'h6666_6666;
        set_id(32'h999, 5'd1, 5'd2, 5'd9, 32'h7, 16'hFFFF, 2'b01);
        tick();
        tick();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_rd",    {27'd0, ex_rd},    32'd0);
        chk("rst_inst",  {30'd0, ex_inst},  32'd0);
        chk("rst_cnt",   {16'd0, cnt},      32'd0);
        chk("rst_cnt4",  {28'd0, cnt4},     32'd0);

        // I0: forwarded A, x0 B despite forwarding enabled
        rst = 1'b0;
        set_id(32'h10, 5'd5, 5'd0, 5'd3, 32'h55, 16'hA5A5, 2'b01);
        is_fwd_a = 1'b1; dat_fwd_a = 32'hDEAD_BEEF; rf1 = 32'h1111_1111;
        is_fwd_b = 1'b1; dat_fwd_b = 32'h2222_2222; rf2 = 32'h99;
        sb.push_back('{32'h10, 32'hDEAD_BEEF, 32'h0, 32'h55, 5'd3, 16'hA5A5, 2'b01});
        #1 chk("i0_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("latency_valid", {31'd0, ex_valid}, 32'd1);

        // I1 back-to-back: x0 A, regfile B
        set_id(32'h14, 5'd0, 5'd9, 5'd4, 32'hFFFF_FFF0, 16'h1234, 2'b10);
        is_fwd_a = 1'b1; dat_fwd_a = 32'h7777_7777; rf1 = 32'h8888_8888;
        is_fwd_b = 1'b0; dat_fwd_b = 32'h3333_3333; rf2 = 32'h0BAD_F00D;
        sb.push_back('{32'h14, 32'h0, 32'h0BAD_F00D, 32'hFFFF_FFF0, 5'd4, 16'h1234, 2'b10});
        tick();
        chk("b2b_pc", ex_pc, 32'h14);

        // I2 under a 3-cycle hazard stall; forwarded value changes each cycle
        set_id(32'h18, 5'd6, 5'd8, 5'd7, 32'h20, 16'h00C3, 2'b01);
        is_fwd_b = 1'b0; rf2 = 32'h4444_4444; is_fwd_a = 1'b1; fwd_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dat_fwd_a = 32'hAAAA_0000 + i;
            #1 chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
            tick();
            chk("stall_bubble_valid", {31'd0, ex_valid}, 32'd0);
            chk("stall_bubble_rd",    {27'd0, ex_rd},    32'd0);
            chk("stall_bubble_inst",  {30'd0, ex_inst},  32'd0);
        end
        chk("stall_cnt3", {16'd0, cnt}, 32'd3);
        fwd_stall = 1'b0; dat_fwd_a = 32'hCAFE_F00D;
        sb.push_back('{32'h18, 32'hCAFE_F00D, 32'h4444_4444, 32'h20, 5'd7, 16'h00C3, 2'b01});
        #1 chk("release_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("release_rd", {27'd0, ex_rd}, 32'd7);

        // I3 at pc 0x100 then held under backpressure with a stall pulse
        set_id(32'h100, 5'd1, 5'd2, 5'd10, 32'h1, 16'h0F0F, 2'b10);
        is_fwd_a = 1'b0; rf1 = 32'h0101_0101; is_fwd_b = 1'b1; dat_fwd_b = 32'h0202_0202;
        sb.push_back('{32'h100, 32'h0101_0101, 32'h0202_0202, 32'h1, 5'd10, 16'h0F0F, 2'b10});
        tick();
        ex_ready = 1'b0;
        set_id(32'h200, 5'd11, 5'd12, 5'd13, 32'h2, 16'hBEEF, 2'b01);
        is_fwd_a = 1'b0; is_fwd_b = 1'b0; rf1 = 32'h1212_1212; rf2 = 32'h3434_3434;
        for (int i = 0; i < 4; i++) begin
            fwd_stall = (i == 1);
            #1 chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
            tick();
            chk("bp_valid", {31'd0, ex_valid}, 32'd1);
            chk("bp_pc",    ex_pc, 32'h100);
            chk("bp_rd",    {27'd0, ex_rd}, 32'd10);
            chk("bp_a",     ex_a, 32'h0101_0101);
            chk("bp_b",     ex_b, 32'h0202_0202);
            chk("bp_inst",  {30'd0, ex_inst}, 32'd2);
        end
        fwd_stall = 1'b0;
        chk("bp_cnt4", {16'd0, cnt}, 32'd4);
        ex_ready = 1'b1;
        sb.push_back('{32'h200, 32'h1212_1212, 32'h3434_3434, 32'h2, 5'd13, 16'hBEEF, 2'b01});
        #1 chk("bp_release_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("i4_pc", ex_pc, 32'h200);

        // Flush with EX full and a valid ID instruction that must be dropped
        ex_ready = 1'b0; flush = 1'b1;
        set_id(32'h300, 5'd3, 5'd4, 5'd14, 32'h3, 16'h5A5A, 2'b01);
        #1 chk("flush_id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_rd",    {27'd0, ex_rd},    32'd0);
        chk("flush_inst",  {30'd0, ex_inst},  32'd0);
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        tick();
        chk("flush_not_taken", {31'd0, ex_valid}, 32'd0);

        // Saturation: 20 more stall cycles on top of the 4 already counted
        cnt_model = 4;
        id_valid = 1'b1; fwd_stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt_model = (cnt_model < 15) ? cnt_model + 1 : 15;
            chk("sat_cnt4_step", {28'd0, cnt4}, cnt_model);
        end
        chk("sat_cnt4_final", {28'd0, cnt4}, 32'hF);
        chk("sat_cnt16",      {16'd0, cnt},  32'd24);
        fwd_stall = 1'b0; id_valid = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("sb_drained", sb.size(), 32'd0);
        chk("sb_pops",    pops,      32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
